serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//   Parallel-in, serial-out transmitter that drives a single-wire bit stream.
//   It is the driving end of the serial link whose far end is a flip-flop sampler/deserializer.
//   It accepts a DATA_W-bit word through a valid/ready handshake.
//   It emits the word as a frame: start bit (0), data LSB first, optional parity, stop bit (1).
//   Each bit is held for CLKS_PER_BIT clock cycles.
// PARAMETERS
//   DATA_W        8   data bits per frame (>=1)
//   CLKS_PER_BIT  4   clock cycles per serial bit (>=1)
//   PARITY_EN     0   1 = insert parity bit between last data bit and stop bit
//   PARITY_ODD    0   0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
// PORTS
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous, active-low reset
//   tx_data   in   DATA_W   word to send; sampled only at handshake
//   tx_valid  in   1        word on tx_data is available
//   tx_ready  out  1        block can accept a word this cycle
//   tx_out    out  1        serial line; idles high
//   busy      out  1        high while a frame is on the line (START..STOP)
// BEHAVIOUR
//   Reset (rst_n=0, async)
//   - State=IDLE, tx_out=1, busy=0, all counters and the shift register cleared.
//   - tx_ready=1 in the first cycle after rst_n rises.
//   - Reset mid-frame aborts the frame: tx_out goes to 1 immediately; no resume, no partial stop bit.
//   States
//   - IDLE: tx_out=1, tx_ready=1, busy=0.
//     Handshake = tx_valid & tx_ready at a rising edge of clk.
//     On handshake: latch tx_data into the shift register, compute the parity bit, go to START.
//   - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: tx_out=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//     After DATA_W bits go to PARITY if PARITY_EN=1, otherwise go to STOP.
//   - PARITY: tx_out = ^data for even parity, ~^data for odd parity, for CLKS_PER_BIT cycles.
//   - STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
//   Timing
//   - tx_out, busy and tx_ready are registered or decoded from the registered state only.
//   - No combinational path from tx_valid to any output.
//   - First start-bit cycle is the cycle after the handshake edge (latency 1).
//   - Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, all with busy=1.
//   - tx_ready=0 from START through STOP.
//     tx_valid and tx_data are ignored during a frame; tx_data may change freely.
//   - Back-to-back: after STOP the block spends exactly 1 cycle in IDLE (tx_out=1, tx_ready=1).
//     If tx_valid=1 in that cycle, the next start bit begins on the following cycle.
//     Minimum inter-frame gap = 1 cycle.
//   Counters
//   - Bit-time counter width = $clog2(CLKS_PER_BIT) (minimum 1).
//   - Bit-time counter counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
//   - Data bit index counts 0..DATA_W-1 and is not reused across frames.
//   - CLKS_PER_BIT=1 is legal: each bit lasts exactly one cycle.
// TESTING
//   Default parameters unless noted. A checker samples tx_out mid-bit and compares full frames.
//   1. Reset
//      rst_n=0 with tx_valid=1 -> tx_out=1, busy=0, no frame starts.
//      Release rst_n -> tx_ready=1 next cycle.
//   2. Send 8'hA5
//      Line bits = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high exactly 40 cycles.
//   3. PARITY_EN=1, PARITY_ODD=0, send 8'h07 -> parity bit=1.
//      Same with PARITY_ODD=1 -> parity bit=0; frame length 44 cycles.
//   4. Back-to-back: hold tx_valid=1, send 8'h55 then 8'hAA; change tx_data mid-frame to 8'hFF.
//      -> Second start bit begins 1 cycle after first stop ends; 8'hFF never transmitted.
//   5. Assert rst_n=0 during data bit 3 of 8'h3C -> tx_out=1 asynchronously.
//      After release, send 8'hC3 -> clean, correct frame.
//   6. CLKS_PER_BIT=1, send 8'hFF -> tx_out = 0 then 9 ones; busy=1 for 10 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter.
// Frame on tx_out: start bit (0), DATA_W data bits LSB first, optional parity
// bit, stop bit (1). Each bit is held for CLKS_PER_BIT cycles of clk.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | line high, ready for a word; handshake loads shift register
//   S_START  | start bit (0) on the line
//   S_DATA   | data bits, shift[0] on the line, shifted right per bit
//   S_PARITY | parity bit computed at load time (only when PARITY_EN=1)
//   S_STOP   | stop bit (1); always followed by at least one cycle of S_IDLE
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     bit_cnt;
   logic [IW-1:0]     bit_idx;
   logic [DATA_W-1:0] shift;
   logic              parity_bit;
   logic              handshake;
   logic              bit_end;
   logic              last_data;

   // Ready and busy decode straight from the registered state, so tx_valid
   // never reaches an output combinationally.
   assign tx_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign handshake = tx_valid & tx_ready;
   assign bit_end   = (bit_cnt == CNT_LAST);
   assign last_data = (bit_idx == IDX_LAST);

   // State register; reset aborts any frame in flight and returns the line high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: every non-idle state lasts whole bit times.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (handshake) state_nxt = S_START;
         end
         S_START: begin
            if (bit_end) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (bit_end && last_data) begin
               state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (bit_end) state_nxt = S_STOP;
         end
         S_STOP: begin
            if (bit_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit-time counter, data bit index, shift register and parity latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
      end else begin
         if (state == S_IDLE || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (handshake) begin
            shift      <= tx_data;
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            bit_idx    <= '0;
         end else if (state == S_DATA && bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= last_data ? '0 : bit_idx + 1'b1;
         end
      end
   end

   // Line driver, decoded from state and registered data only.
   always_comb begin
      tx_out = 1'b1;
      case (state)
         S_START:  tx_out = 1'b0;
         S_DATA:   tx_out = shift[0];
         S_PARITY: tx_out = parity_bit;
         default:  tx_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four instances (default, even parity,
// odd parity, one clock per bit) share clock, reset and the input handshake.
module tb_serial_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       o [4];
   logic       b [4];
   logic       r [4];

   int tests;
   int fails;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(r[0]), .tx_out(o[0]), .busy(b[0]));
   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(r[1]), .tx_out(o[1]), .busy(b[1]));
   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(r[2]), .tx_out(o[2]), .busy(b[2]));
   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_cpb1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(r[3]), .tx_out(o[3]), .busy(b[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until every instance is idle.
   task automatic wait_idle(input string tag);
      logic all_idle;
      all_idle = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         all_idle = r[0] & r[1] & r[2] & r[3];
         if (all_idle) break;
      end
      chk({tag, "_idle_timeout"}, all_idle, 1'b1);
   endtask

   // Present a word at a negedge; returns just after the handshake edge.
   task automatic send(input int s, input logic [7:0] d, input bit hold, input string tag);
      wait_idle(tag);
      tx_data  = d;
      tx_valid = 1'b1;
      chk({tag, "_pre_ready"}, r[s], 1'b1);
      chk({tag, "_pre_busy"}, b[s], 1'b0);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   // Called just after the handshake edge: checks every cycle of the frame
   // and the single idle cycle after it. tx_data is rewritten at cycles c1/c2.
   task automatic check_frame(input int s, input int cpb, input logic [15:0] bits,
                              input int nbits, input string tag,
                              input int c1, input logic [7:0] d1,
                              input int c2, input logic [7:0] d2);
      for (int k = 0; k < nbits * cpb; k++) begin
         @(negedge clk);
         if (k == c1) tx_data = d1;
         if (k == c2) tx_data = d2;
         chk($sformatf("%s_out_c%0d", tag, k), o[s], bits[k / cpb]);
         chk($sformatf("%s_busy_c%0d", tag, k), b[s], 1'b1);
         chk($sformatf("%s_ready_c%0d", tag, k), r[s], 1'b0);
      end
      @(negedge clk);
      chk({tag, "_end_out"}, o[s], 1'b1);
      chk({tag, "_end_busy"}, b[s], 1'b0);
      chk({tag, "_end_ready"}, r[s], 1'b1);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'hA5;

      // Reset held with tx_valid high: line idle, no frame.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_out_def", o[0], 1'b1);
         chk("rst_busy_def", b[0], 1'b0);
         chk("rst_out_cpb1", o[3], 1'b1);
         chk("rst_busy_cpb1", b[3], 1'b0);
      end
      rst_n    = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", r[0], 1'b1);
      chk("post_rst_busy", b[0], 1'b0);
      chk("post_rst_out", o[0], 1'b1);

      // 8'hA5, default framing: 0,1,0,1,0,0,1,0,1,1
      send(0, 8'hA5, 1'b0, "a5");
      check_frame(0, 4, 16'b11_0100_1010, 10, "a5", -1, 8'h00, -1, 8'h00);

      // 8'h07 with even parity -> parity bit 1
      send(1, 8'h07, 1'b0, "p_even");
      check_frame(1, 4, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "p_even", -1, 8'h00, -1, 8'h00);

      // 8'h07 with odd parity -> parity bit 0, 44 cycles
      send(2, 8'h07, 1'b0, "p_odd");
      check_frame(2, 4, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "p_odd", -1, 8'h00, -1, 8'h00);

      // Back-to-back: 8'h55 then 8'hAA; 8'hFF on tx_data mid-frame is ignored.
      send(0, 8'h55, 1'b1, "b2b55");
      check_frame(0, 4, {6'b0, 1'b1, 8'h55, 1'b0}, 10, "b2b55", 20, 8'hFF, 35, 8'hAA);
      check_frame(0, 4, {6'b0, 1'b1, 8'hAA, 1'b0}, 10, "b2bAA", -1, 8'h00, -1, 8'h00);
      tx_valid = 1'b0;

      // Reset during data bit 3 of 8'h3C (frame cycles 16..19).
      send(0, 8'h3C, 1'b0, "r3c");
      for (int k = 0; k < 18; k++) @(negedge clk);
      chk("r3c_busy_before", b[0], 1'b1);
      chk("r3c_bit3_before", o[0], 1'b1);
      @(negedge clk);
      chk("r3c_bit3_last", o[0], 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("r3c_async_out", o[0], 1'b1);
      chk("r3c_async_busy", b[0], 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("r3c_rel_ready", r[0], 1'b1);
      chk("r3c_rel_out", o[0], 1'b1);

      // Clean frame after the aborted one.
      send(0, 8'hC3, 1'b0, "c3");
      check_frame(0, 4, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, "c3", -1, 8'h00, -1, 8'h00);

      // One clock per bit: 0 then nine ones, busy for 10 cycles.
      send(3, 8'hFF, 1'b0, "cpb1");
      check_frame(3, 1, 16'b11_1111_1110, 10, "cpb1", -1, 8'h00, -1, 8'h00);

      wait_idle("final");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
